// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
// Optional build macro used by the top level: WB_ZERO_REG_FILTER_EN.
package regfile_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int NUM_REGS      = 32;
  localparam int WB_DATA_MAX_W = 64;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;

  // The data field is sized for the widest supported writeback; narrower
  // builds use the low DATA_W bits.
  typedef struct packed {
    logic                     valid;
    logic [REG_ADDR_W-1:0]    addr;
    logic [WB_DATA_MAX_W-1:0] data;
  } wb_req_t;

  typedef enum logic [0:0] {
    PRIO0  = 1'b0,
    FORCE1 = 1'b1
  } arb_state_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    reg_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << addr;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one busy flop per architectural register.
// Issue sets a bit, an accepted writeback clears it; set wins, XZR never pending.
module wb_scoreboard
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  output logic [NUM_REGS-1:0]   busy
);

  logic [NUM_REGS-1:0] set_mask_s;
  logic [NUM_REGS-1:0] clr_mask_s;
  logic [NUM_REGS-1:0] busy_next_s;
  logic [NUM_REGS-1:0] busy_r;

  // Set/clear decode and next-state merge
  always_comb begin
    set_mask_s  = {NUM_REGS{1'b0}};
    clr_mask_s  = {NUM_REGS{1'b0}};
    if (set_en) begin
      set_mask_s = reg_onehot(set_addr);
    end else begin
      set_mask_s = {NUM_REGS{1'b0}};
    end
    if (clr_en) begin
      clr_mask_s = reg_onehot(clr_addr);
    end else begin
      clr_mask_s = {NUM_REGS{1'b0}};
    end
    busy_next_s           = (busy_r & ~clr_mask_s) | set_mask_s;
    busy_next_s[ZERO_REG] = 1'b0;
  end

  // Busy flops
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= busy_next_s;
    end
  end

  assign busy = busy_r;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline WB (req0) and
// the multi-cycle unit (req1). Build macro: WB_ZERO_REG_FILTER_EN suppresses XZR writes.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int MAX_WAIT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [REG_ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0]     req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [REG_ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0]     req1_data,
  output logic                  req1_ready,
  input  logic                  iss_valid,
  input  logic [REG_ADDR_W-1:0] iss_addr,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic [NUM_REGS-1:0]   busy
);

  localparam int                CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_WAIT);

  arb_state_t            state_r;
  logic [CNT_W-1:0]      wait_cnt_r;
  logic [CNT_W-1:0]      cnt_inc_s;
  logic                  req0_ready_s;
  logic                  req1_ready_s;
  logic                  wr_en_s;
  wb_req_t               sel_req_s;
  logic                  reg_write_r;
  logic [REG_ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0]     wr_data_r;

  // Grant decode: ready only ever follows valid, and nothing is granted in reset
  always_comb begin
    req0_ready_s = 1'b0;
    req1_ready_s = 1'b0;
    if (reset) begin
      req0_ready_s = 1'b0;
      req1_ready_s = 1'b0;
    end else if (state_r == FORCE1) begin
      req0_ready_s = 1'b0;
      req1_ready_s = req1_valid;
    end else begin
      req0_ready_s = req0_valid;
      req1_ready_s = req1_valid && !req0_valid;
    end
  end

  // Winning request mux
  always_comb begin
    sel_req_s = '{valid: 1'b0, addr: {REG_ADDR_W{1'b0}}, data: {WB_DATA_MAX_W{1'b0}}};
    if (req1_ready_s) begin
      sel_req_s = '{valid: 1'b1, addr: req1_addr, data: WB_DATA_MAX_W'(req1_data)};
    end else if (req0_ready_s) begin
      sel_req_s = '{valid: 1'b1, addr: req0_addr, data: WB_DATA_MAX_W'(req0_data)};
    end else begin
      sel_req_s = '{valid: 1'b0, addr: {REG_ADDR_W{1'b0}}, data: {WB_DATA_MAX_W{1'b0}}};
    end
  end

`ifdef WB_ZERO_REG_FILTER_EN
  assign wr_en_s = sel_req_s.valid && (sel_req_s.addr != ZERO_REG);
`else
  assign wr_en_s = sel_req_s.valid;
`endif

  assign cnt_inc_s = wait_cnt_r + CNT_W'(1);

  // Arbitration FSM, starvation counter and registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= PRIO0;
      wait_cnt_r  <= {CNT_W{1'b0}};
      reg_write_r <= 1'b0;
      wr_addr_r   <= {REG_ADDR_W{1'b0}};
      wr_data_r   <= {DATA_W{1'b0}};
    end else begin
      reg_write_r <= wr_en_s;
      if (sel_req_s.valid) begin
        wr_addr_r <= sel_req_s.addr;
        wr_data_r <= sel_req_s.data[DATA_W-1:0];
      end else begin
        wr_addr_r <= wr_addr_r;
        wr_data_r <= wr_data_r;
      end
      case (state_r)
        PRIO0: begin
          if (!req1_valid || req1_ready_s) begin
            wait_cnt_r <= {CNT_W{1'b0}};
          end else if (cnt_inc_s == MAX_CNT) begin
            wait_cnt_r <= cnt_inc_s;
            state_r    <= FORCE1;
          end else begin
            wait_cnt_r <= cnt_inc_s;
          end
        end
        FORCE1: begin
          // A withdrawn req1 also releases the force so req0 cannot be starved.
          if (req1_ready_s || !req1_valid) begin
            wait_cnt_r <= {CNT_W{1'b0}};
            state_r    <= PRIO0;
          end else begin
            wait_cnt_r <= wait_cnt_r;
          end
        end
        default: begin
          wait_cnt_r <= {CNT_W{1'b0}};
          state_r    <= PRIO0;
        end
      endcase
    end
  end

  wb_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (iss_valid),
    .set_addr (iss_addr),
    .clr_en   (sel_req_s.valid),
    .clr_addr (sel_req_s.addr),
    .busy     (busy)
  );

  assign req0_ready = req0_ready_s;
  assign req1_ready = req1_ready_s;
  assign RegWrite   = reg_write_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against a behavioural model of arbitration, write port and scoreboard.
module tb_regfile_wb_arbiter;

  localparam int MAX_WAIT = 3;
`ifdef WB_ZERO_REG_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, iss_valid;
  logic [4:0]  req0_addr, req1_addr, iss_addr;
  logic [63:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        RegWrite;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic [31:0] busy;

  int checks = 0;
  int errors = 0;

  // model state
  logic        m_rw;
  logic [4:0]  m_addr;
  logic [63:0] m_data;
  logic [31:0] m_busy;
  int          m_refused;
  logic        exp_r0, exp_r1, obs_r0, obs_r1;

  regfile_wb_arbiter #(.DATA_W(64), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .RegWrite(RegWrite), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: req1 is forced once it has been refused MAX_WAIT times in a row.
  task automatic model_step();
    bit forced;
    if (reset) begin
      exp_r0 = 1'b0; exp_r1 = 1'b0;
      m_rw = 1'b0; m_addr = 5'd0; m_data = 64'd0; m_busy = 32'd0; m_refused = 0;
    end else begin
      forced = (m_refused >= MAX_WAIT);
      exp_r1 = req1_valid && (forced || !req0_valid);
      exp_r0 = req0_valid && !forced;
      if (exp_r1) begin
        m_rw = !(FILT && req1_addr == 5'd31); m_addr = req1_addr; m_data = req1_data;
        m_busy[req1_addr] = 1'b0;
      end else if (exp_r0) begin
        m_rw = !(FILT && req0_addr == 5'd31); m_addr = req0_addr; m_data = req0_data;
        m_busy[req0_addr] = 1'b0;
      end else begin
        m_rw = 1'b0;
      end
      m_refused = (req1_valid && !exp_r1) ? m_refused + 1 : 0;
      if (iss_valid) m_busy[iss_addr] = 1'b1;
      m_busy[31] = 1'b0;
    end
  endtask

  // Inputs are already driven; sample readies mid-cycle, advance model, cross the edge.
  task automatic cycle();
    #2;
    obs_r0 = req0_ready;
    obs_r1 = req1_ready;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0; req1_valid = 1'b0; iss_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 64'h11;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 64'h22;
    iss_valid = 1'b1; iss_addr = 5'd6;
    for (int k = 0; k < 2; k++) begin
      cycle();
      checks++; if (obs_r0 !== 1'b0) begin errors++; $display("FAIL reset_r0_ready got=%b exp=0", obs_r0); end
      checks++; if (obs_r1 !== 1'b0) begin errors++; $display("FAIL reset_r1_ready got=%b exp=0", obs_r1); end
      checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got=%b exp=0", RegWrite); end
      checks++; if (busy !== 32'd0) begin errors++; $display("FAIL reset_busy got=%h exp=0", busy); end
      checks++; if (wr_addr !== 5'd0 || wr_data !== 64'd0) begin
        errors++; $display("FAIL reset_wr got=%0d/%h exp=0/0", wr_addr, wr_data); end
    end
    reset = 1'b0;
    idle();
    cycle();
  endtask

  task automatic test_single_req0();
    idle();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 64'hA5;
    cycle();
    checks++; if (obs_r0 !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", obs_r0); end
    checks++; if (RegWrite !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 64'hA5) begin
      errors++; $display("FAIL single_write got=%b/%0d/%h exp=1/5/a5", RegWrite, wr_addr, wr_data); end
    idle();
    cycle();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL single_idle_regwrite got=%b exp=0", RegWrite); end
  endtask

  task automatic test_contention();
    idle();
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 64'h7777;
    for (int k = 1; k <= 5; k++) begin
      req0_valid = 1'b1; req0_addr = 5'(k); req0_data = 64'(k * 16);
      cycle();
      checks++; if (obs_r1 !== (k == 4)) begin errors++; $display("FAIL contend_r1 k=%0d got=%b exp=%b", k, obs_r1, k == 4); end
      checks++; if (obs_r0 !== (k != 4)) begin errors++; $display("FAIL contend_r0 k=%0d got=%b exp=%b", k, obs_r0, k != 4); end
      checks++; if (wr_addr !== ((k == 4) ? 5'd7 : 5'(k))) begin
        errors++; $display("FAIL contend_addr k=%0d got=%0d exp=%0d", k, wr_addr, (k == 4) ? 7 : k); end
      if (obs_r1) req1_valid = 1'b0;
    end
    idle();
    cycle();
  endtask

  task automatic test_scoreboard();
    idle();
    iss_valid = 1'b1; iss_addr = 5'd9;
    cycle();
    iss_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      checks++; if (busy[9] !== (c <= 4)) begin errors++; $display("FAIL sb_busy9 cyc=%0d got=%b exp=%b", c, busy[9], c <= 4); end
      req1_valid = (c == 4); req1_addr = 5'd9; req1_data = 64'h99;
      cycle();
    end
    idle();
    checks++; if (busy[9] !== 1'b0) begin errors++; $display("FAIL sb_cleared got=%b exp=0", busy[9]); end
    iss_valid = 1'b1; iss_addr = 5'd9;
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 64'h9A;
    cycle();
    checks++; if (busy[9] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got=%b exp=1", busy[9]); end
    checks++; if (busy !== m_busy) begin errors++; $display("FAIL sb_model got=%h exp=%h", busy, m_busy); end
    idle();
    cycle();
  endtask

  task automatic test_xzr();
    idle();
    iss_valid = 1'b1; iss_addr = 5'd31;
    req0_valid = 1'b1; req0_addr = 5'd31; req0_data = 64'h3131;
    cycle();
    checks++; if (obs_r0 !== 1'b1) begin errors++; $display("FAIL xzr_ready got=%b exp=1", obs_r0); end
    checks++; if (RegWrite !== !FILT) begin errors++; $display("FAIL xzr_regwrite got=%b exp=%b", RegWrite, !FILT); end
    checks++; if (wr_addr !== 5'd31 || wr_data !== 64'h3131) begin
      errors++; $display("FAIL xzr_wr got=%0d/%h exp=31/3131", wr_addr, wr_data); end
    checks++; if (busy[31] !== 1'b0) begin errors++; $display("FAIL xzr_busy31 got=%b exp=0", busy[31]); end
    idle();
    cycle();
  endtask

  task automatic test_reset_in_force();
    idle();
    req1_valid = 1'b1; req1_addr = 5'd12; req1_data = 64'hC0C0;
    req0_valid = 1'b1; req0_addr = 5'd2; req0_data = 64'h2;
    for (int k = 0; k < 3; k++) cycle();
    reset = 1'b1;
    cycle();
    checks++; if (obs_r1 !== 1'b0 || obs_r0 !== 1'b0) begin
      errors++; $display("FAIL rstforce_ready got=%b%b exp=00", obs_r0, obs_r1); end
    checks++; if (RegWrite !== 1'b0 || busy !== 32'd0) begin
      errors++; $display("FAIL rstforce_out got=%b/%h exp=0/0", RegWrite, busy); end
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      checks++; if (obs_r1 !== (k == 4)) begin errors++; $display("FAIL rstforce_r1 k=%0d got=%b exp=%b", k, obs_r1, k == 4); end
      checks++; if (wr_addr !== ((k == 4) ? 5'd12 : 5'd2)) begin
        errors++; $display("FAIL rstforce_addr k=%0d got=%0d exp=%0d", k, wr_addr, (k == 4) ? 12 : 2); end
      if (obs_r1) req1_valid = 1'b0;
    end
    idle();
    cycle();
  endtask

  task automatic test_random();
    idle();
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid && $urandom_range(0, 2) != 0) begin
        req0_valid = 1'b1; req0_addr = 5'($urandom_range(0, 31)); req0_data = {$urandom, $urandom};
      end
      if (!req1_valid && $urandom_range(0, 1) != 0) begin
        req1_valid = 1'b1; req1_addr = 5'($urandom_range(0, 31)); req1_data = {$urandom, $urandom};
      end
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_addr  = 5'($urandom_range(0, 31));
      cycle();
      checks++; if (obs_r0 !== exp_r0 || obs_r1 !== exp_r1) begin
        errors++; $display("FAIL rand_ready cyc=%0d got=%b%b exp=%b%b", i, obs_r0, obs_r1, exp_r0, exp_r1); end
      checks++; if (RegWrite !== m_rw) begin errors++; $display("FAIL rand_regwrite cyc=%0d got=%b exp=%b", i, RegWrite, m_rw); end
      checks++; if (wr_addr !== m_addr || wr_data !== m_data) begin
        errors++; $display("FAIL rand_wr cyc=%0d got=%0d/%h exp=%0d/%h", i, wr_addr, wr_data, m_addr, m_data); end
      checks++; if (busy !== m_busy) begin errors++; $display("FAIL rand_busy cyc=%0d got=%h exp=%h", i, busy, m_busy); end
      if (exp_r0) req0_valid = 1'b0;
      if (exp_r1) req1_valid = 1'b0;
    end
    idle();
    cycle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    req0_addr = 5'd0; req0_data = 64'd0;
    req1_addr = 5'd0; req1_data = 64'd0;
    iss_addr = 5'd0;
    test_reset();
    test_single_req0();
    test_contention();
    test_scoreboard();
    test_xzr();
    test_reset_in_force();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
